// File: rtl/axi_lite_regbank_n.sv
// AXI4-Lite slave exposing C_NUM_REGS byte-writable registers as a flat reg_q bus.
// Define AXIL_REGBANK_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi_lite_regbank_n #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_NUM_REGS         = 16,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                                       S_AXI_ACLK,
    input  logic                                       S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
    input  logic [2:0]                                 S_AXI_AWPROT,
    input  logic                                       S_AXI_AWVALID,
    output logic                                       S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
    input  logic                                       S_AXI_WVALID,
    output logic                                       S_AXI_WREADY,
    output logic [1:0]                                 S_AXI_BRESP,
    output logic                                       S_AXI_BVALID,
    input  logic                                       S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
    input  logic [2:0]                                 S_AXI_ARPROT,
    input  logic                                       S_AXI_ARVALID,
    output logic                                       S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_RDATA,
    output logic [1:0]                                 S_AXI_RRESP,
    output logic                                       S_AXI_RVALID,
    input  logic                                       S_AXI_RREADY,
    output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_q
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int NB       = DW / 8;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

`ifdef AXIL_REGBANK_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}           r_state_t;

    w_state_t          w_state, w_state_n;
    r_state_t          r_state, r_state_n;
    logic              aw_held, aw_held_n, w_held, w_held_n;
    logic              awready_q, awready_n, wready_q, wready_n;
    logic              bvalid_q, bvalid_n;
    logic [1:0]        bresp_q;
    logic [IDX_W-1:0]  aw_idx;
    logic [DW-1:0]     wdata_q;
    logic [NB-1:0]     wstrb_q;
    logic              arready_q, arready_n, rvalid_q, rvalid_n;
    logic [1:0]        rresp_q;
    logic [DW-1:0]     rdata_q;
    logic              aw_hs, w_hs, ar_hs;
    logic              w_hit, r_hit;
    logic [IDX_W-1:0]  ar_idx;
    logic [DW-1:0]     rd_word;
    logic [DW-1:0]     regs [C_NUM_REGS];

    // Protection bits and sub-word address bits carry no meaning for this bank.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign aw_hs  = S_AXI_AWVALID && awready_q;
    assign w_hs   = S_AXI_WVALID && wready_q;
    assign ar_hs  = S_AXI_ARVALID && arready_q;
    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

    // Index decode by comparison keeps out-of-range indices from ever touching the array.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_hit   = 1'b0;
        r_hit   = 1'b0;
        rd_word = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (aw_idx == IDX_W'(i)) w_hit = 1'b1;
            if (ar_idx == IDX_W'(i)) begin
                r_hit   = 1'b1;
                rd_word = regs[i];
            end
        end
    end

    always_comb begin
        w_state_n = w_state;
        aw_held_n = aw_held;
        w_held_n  = w_held;
        bvalid_n  = bvalid_q;
        case (w_state)
            W_IDLE: begin
                aw_held_n = aw_held || aw_hs;
                w_held_n  = w_held || w_hs;
                if (aw_held_n && w_held_n) w_state_n = W_COMMIT;
            end
            W_COMMIT: begin
                bvalid_n  = 1'b1;
                w_state_n = W_RESP;
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_n  = 1'b0;
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
        awready_n = (w_state_n == W_IDLE) && !aw_held_n;
        wready_n  = (w_state_n == W_IDLE) && !w_held_n;
    end

    always_comb begin
        r_state_n = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_n = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_state_n = R_IDLE;
            default: r_state_n = R_IDLE;
        endcase
        arready_n = (r_state_n == R_IDLE);
        rvalid_n  = (r_state_n == R_DATA);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            aw_idx    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            // NOTE: the bank is a set of architectural registers, not a RAM, so clearing it is intended.
            for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
        end else begin
            w_state   <= w_state_n;
            aw_held   <= aw_held_n;
            w_held    <= w_held_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            if (aw_hs) aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (w_state == W_COMMIT) begin
                bresp_q <= (!w_hit && SLVERR_EN) ? 2'b10 : 2'b00;
                for (int i = 0; i < C_NUM_REGS; i++) begin
                    for (int b = 0; b < NB; b++) begin
                        if (aw_idx == IDX_W'(i) && wstrb_q[b])
                            regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    // A read sampled on the commit edge sees the pre-write register value.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            r_state   <= r_state_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            if (ar_hs) begin
                rdata_q <= rd_word;
                rresp_q <= (!r_hit && SLVERR_EN) ? 2'b10 : 2'b00;
            end
        end
    end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DW +: DW] = regs[g];
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_lite_regbank_n.sv
// Directed bench for axi_lite_regbank_n (default 32-bit, 16-register build).
module tb_axi_lite_regbank_n;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int AW = 8;

`ifdef AXIL_REGBANK_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [AW-1:0]    S_AXI_AWADDR = '0;
    logic [2:0]       S_AXI_AWPROT = '0;
    logic             S_AXI_AWVALID = 1'b0;
    logic             S_AXI_AWREADY;
    logic [DW-1:0]    S_AXI_WDATA = '0;
    logic [DW/8-1:0]  S_AXI_WSTRB = '0;
    logic             S_AXI_WVALID = 1'b0;
    logic             S_AXI_WREADY;
    logic [1:0]       S_AXI_BRESP;
    logic             S_AXI_BVALID;
    logic             S_AXI_BREADY = 1'b0;
    logic [AW-1:0]    S_AXI_ARADDR = '0;
    logic [2:0]       S_AXI_ARPROT = '0;
    logic             S_AXI_ARVALID = 1'b0;
    logic             S_AXI_ARREADY;
    logic [DW-1:0]    S_AXI_RDATA;
    logic [1:0]       S_AXI_RRESP;
    logic             S_AXI_RVALID;
    logic             S_AXI_RREADY = 1'b0;
    logic [NR*DW-1:0] reg_q;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model [NR];

    axi_lite_regbank_n #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_NUM_REGS(NR),
        .C_S_AXI_ADDR_WIDTH(AW)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rstn),
        .S_AXI_AWADDR(S_AXI_AWADDR),
        .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA),
        .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA),
        .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY),
        .reg_q(reg_q)
    );

    always #5 clk = ~clk;

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    // Drives one write; inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly, output logic [1:0] resp, output bit ok,
                             output int bwait, output bit held_ok, output int extra);
        int cyc = 0;
        bit aw_done = 1'b0, w_done = 1'b0, aw_fire, w_fire;
        logic [1:0] r0;
        ok = 1'b1; held_ok = 1'b1; extra = 0; bwait = 0; resp = 2'bxx;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        while (ok && !(aw_done && w_done)) begin
            if (cyc >= 100) ok = 1'b0;
            else begin
                if (!aw_done && cyc == aw_dly) S_AXI_AWVALID = 1'b1;
                if (!w_done && cyc == w_dly) S_AXI_WVALID = 1'b1;
                aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
                w_fire  = S_AXI_WVALID && S_AXI_WREADY;
                @(posedge clk); #1; cyc++;
                if (aw_fire) begin S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
                if (w_fire)  begin S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
            end
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        while (ok && !S_AXI_BVALID) begin
            if (bwait >= 100) ok = 1'b0;
            else begin @(posedge clk); #1; bwait++; end
        end
        if (ok) begin
            r0 = S_AXI_BRESP;
            for (int i = 0; i < b_dly; i++) begin
                @(posedge clk); #1;
                if (!S_AXI_BVALID || S_AXI_BRESP !== r0) held_ok = 1'b0;
            end
            S_AXI_BREADY = 1'b1;
            resp = S_AXI_BRESP;
            @(posedge clk); #1;
            S_AXI_BREADY = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (S_AXI_BVALID) extra++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int ar_dly,
                            output logic [DW-1:0] data, output logic [1:0] resp,
                            output bit ok, output int rwait);
        int cyc = 0;
        bit done = 1'b0, fire;
        ok = 1'b1; rwait = 0; data = 'x; resp = 2'bxx;
        S_AXI_ARADDR = addr;
        while (ok && !done) begin
            if (cyc >= 100) ok = 1'b0;
            else begin
                if (cyc == ar_dly) S_AXI_ARVALID = 1'b1;
                fire = S_AXI_ARVALID && S_AXI_ARREADY;
                @(posedge clk); #1; cyc++;
                if (fire) begin S_AXI_ARVALID = 1'b0; done = 1'b1; end
            end
        end
        S_AXI_ARVALID = 1'b0;
        while (ok && !S_AXI_RVALID) begin
            if (rwait >= 100) ok = 1'b0;
            else begin @(posedge clk); #1; rwait++; end
        end
        if (ok) begin
            S_AXI_RREADY = 1'b1;
            data = S_AXI_RDATA;
            resp = S_AXI_RRESP;
            @(posedge clk); #1;
            S_AXI_RREADY = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] d; logic [1:0] r; bit ok; int rw;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
             S_AXI_BRESP, S_AXI_RRESP} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got aw/w/ar/b/r=%b%b%b%b%b bresp=%b rresp=%b, want all 0",
                     S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
                     S_AXI_BRESP, S_AXI_RRESP);
        end
        checks++;
        if (S_AXI_RDATA !== '0 || reg_q !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h reg_q=%h, want 0", S_AXI_RDATA, reg_q);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, want 111",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        for (int i = 0; i < NR; i++) begin
            model[i] = '0;
            axi_read(AW'(i * 4), 0, d, r, ok, rw);
            checks++;
            if (!ok || rw != 0 || d !== 32'h0 || r !== 2'b00) begin
                errors++;
                $display("FAIL reset_read[%0d]: ok=%0d lat=%0d data=%h resp=%b, want lat 0 data 0 resp 00",
                         i, ok, rw, d, r);
            end
        end
    endtask

    task automatic test_basic();
        logic [1:0] r; bit ok, held; int bw, ex, rw; logic [DW-1:0] d;
        for (int i = 0; i < 4; i++) begin
            axi_write(AW'(i * 4), DW'(i + 1), 4'hF, 0, 0, 0, r, ok, bw, held, ex);
            model[i] = DW'(i + 1);
            checks++;
            if (!ok || bw != 1 || r !== 2'b00 || ex != 0) begin
                errors++;
                $display("FAIL basic_write[%0d]: ok=%0d bwait=%0d resp=%b extra=%0d, want 1/1/00/0",
                         i, ok, bw, r, ex);
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(AW'(i * 4), 0, d, r, ok, rw);
            checks++;
            if (!ok || d !== DW'(i + 1) || r !== 2'b00) begin
                errors++;
                $display("FAIL basic_read[%0d]: ok=%0d data=%h resp=%b, want %h 00", i, ok, d, r, i + 1);
            end
        end
        checks++;
        if (reg_q[127:0] !== 128'h00000004_00000003_00000002_00000001) begin
            errors++;
            $display("FAIL basic_reg_q: got %h, want 00000004000000030000000200000001", reg_q[127:0]);
        end
        axi_read(8'h0F, 0, d, r, ok, rw);
        checks++;
        if (!ok || d !== 32'h4) begin
            errors++;
            $display("FAIL low_addr_ignored: data=%h, want 00000004", d);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] r; bit ok, held; int bw, ex, rw; logic [DW-1:0] d;
        axi_write(8'h14, 32'hAABBCCDD, 4'hF, 0, 0, 0, r, ok, bw, held, ex);
        axi_write(8'h14, 32'h11223344, 4'b0101, 0, 0, 0, r, ok, bw, held, ex);
        model[5] = 32'hAA22CC44;
        axi_read(8'h14, 0, d, r, ok, rw);
        checks++;
        if (!ok || d !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL strobe_merge: data=%h, want AA22CC44", d);
        end
        axi_write(8'h14, 32'hFFFFFFFF, 4'h0, 0, 0, 0, r, ok, bw, held, ex);
        checks++;
        if (!ok || r !== 2'b00 || reg_q !== model_flat()) begin
            errors++;
            $display("FAIL strobe_zero: ok=%0d resp=%b reg5=%h, want resp 00 reg5 AA22CC44",
                     ok, r, reg_q[5*DW +: DW]);
        end
    endtask

    task automatic test_skew();
        int aw_d [3] = '{3, 0, 0};
        int w_d  [3] = '{0, 3, 0};
        logic [1:0] r; bit ok, held; int bw, ex, rw; logic [DW-1:0] d, v;
        for (int k = 0; k < 3; k++) begin
            v = 32'hC0DE0000 + DW'(k);
            axi_write(AW'((6 + k) * 4), v, 4'hF, aw_d[k], w_d[k], 5, r, ok, bw, held, ex);
            model[6 + k] = v;
            checks++;
            if (!ok || bw != 1 || !held || ex != 0 || r !== 2'b00) begin
                errors++;
                $display("FAIL skew_resp[%0d]: ok=%0d bwait=%0d held=%0d extra=%0d resp=%b, want 1/1/1/0/00",
                         k, ok, bw, held, ex, r);
            end
            axi_read(AW'((6 + k) * 4), 0, d, r, ok, rw);
            checks++;
            if (!ok || d !== v) begin
                errors++;
                $display("FAIL skew_data[%0d]: data=%h, want %h", k, d, v);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] r; bit ok, held; int bw, ex, rw; logic [DW-1:0] d;
        axi_write(8'h40, 32'h12345678, 4'hF, 0, 0, 0, r, ok, bw, held, ex);
        checks++;
        if (!ok || r !== OOR_RESP || reg_q !== model_flat()) begin
            errors++;
            $display("FAIL oor_write: ok=%0d bresp=%b reg_q_match=%0d, want bresp %b and unchanged regs",
                     ok, r, reg_q === model_flat(), OOR_RESP);
        end
        axi_read(8'h40, 0, d, r, ok, rw);
        checks++;
        if (!ok || d !== 32'h0 || r !== OOR_RESP) begin
            errors++;
            $display("FAIL oor_read: data=%h rresp=%b, want 00000000 %b", d, r, OOR_RESP);
        end
    endtask

    task automatic test_collision();
        logic [1:0] wr, rr; bit wok, rok, held; int bw, ex, rw; logic [DW-1:0] d;
        axi_write(8'h08, 32'h5, 4'hF, 0, 0, 0, wr, wok, bw, held, ex);
        fork
            axi_write(8'h08, 32'h9, 4'hF, 0, 0, 0, wr, wok, bw, held, ex);
            axi_read(8'h08, 1, d, rr, rok, rw);
        join
        model[2] = 32'h9;
        checks++;
        if (!rok || !wok || d !== 32'h5) begin
            errors++;
            $display("FAIL collision_old: data=%h, want 00000005", d);
        end
        axi_read(8'h08, 0, d, rr, rok, rw);
        checks++;
        if (!rok || d !== 32'h9) begin
            errors++;
            $display("FAIL collision_new: data=%h, want 00000009", d);
        end
    endtask

    task automatic test_reset_mid();
        bit aw_f, w_f; int cnt = 0; logic [DW-1:0] d; logic [1:0] r; bit ok; int rw;
        S_AXI_AWADDR = 8'h30; S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        while (!S_AXI_BVALID && cnt < 20) begin
            aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
            w_f  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge clk); #1; cnt++;
            if (aw_f) S_AXI_AWVALID = 1'b0;
            if (w_f)  S_AXI_WVALID  = 1'b0;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        checks++;
        if (S_AXI_BVALID !== 1'b1 || reg_q[12*DW +: DW] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL midrst_setup: bvalid=%b reg12=%h, want 1 DEADBEEF", S_AXI_BVALID, reg_q[12*DW +: DW]);
        end
        rstn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b0 || reg_q !== '0) begin
            errors++;
            $display("FAIL midrst_drop: bvalid=%b awready=%b reg_q_zero=%0d, want 0 0 1",
                     S_AXI_BVALID, S_AXI_AWREADY, reg_q === '0);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) begin
            model[i] = '0;
            axi_read(AW'(i * 4), 0, d, r, ok, rw);
            checks++;
            if (!ok || d !== 32'h0 || r !== 2'b00) begin
                errors++;
                $display("FAIL midrst_read[%0d]: ok=%0d data=%h resp=%b, want 0", i, ok, d, r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_skew();
        test_out_of_range();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_regbank_n.md
# axi_lite_regbank_n

Parametrised AXI4-Lite slave register bank: the next generation of the fixed 4-register slave in our on-board AXI IP. Holds `C_NUM_REGS` read/write registers of `C_S_AXI_DATA_WIDTH` bits, exposed to fabric logic as a flat bus. Adds the following over the previous block:
- byte-strobe writes;
- independent AW/W acceptance;
- defined out-of-range decoding;
- a deterministic read/write collision rule.

## Interface
Parameters:
- `C_S_AXI_DATA_WIDTH`, 32, data width; 32 or 64 only.
- `C_NUM_REGS`, 16, register count; 1..256.
- `C_S_AXI_ADDR_WIDTH`, 8, byte-address width; must satisfy 2^ADDR_WIDTH ≥ C_NUM_REGS·(DW/8).

Ports:
- `S_AXI_ACLK` in 1: the single clock.
- `S_AXI_ARESETN` in 1: reset; synchronous, active-low.
- `S_AXI_AWADDR` in ADDR_WIDTH; `S_AXI_AWPROT` in 3 (ignored); `S_AXI_AWVALID` in 1; `S_AXI_AWREADY` out 1.
- `S_AXI_WDATA` in DW; `S_AXI_WSTRB` in DW/8; `S_AXI_WVALID` in 1; `S_AXI_WREADY` out 1.
- `S_AXI_BRESP` out 2; `S_AXI_BVALID` out 1; `S_AXI_BREADY` in 1.
- `S_AXI_ARADDR` in ADDR_WIDTH; `S_AXI_ARPROT` in 3 (ignored); `S_AXI_ARVALID` in 1; `S_AXI_ARREADY` out 1.
- `S_AXI_RDATA` out DW; `S_AXI_RRESP` out 2; `S_AXI_RVALID` out 1; `S_AXI_RREADY` in 1.
- `reg_q` out C_NUM_REGS·DW: register i occupies bits [i·DW +: DW].

## Operation
Address decode:
- Register index = addr >> log2(DW/8). The low log2(DW/8) address bits are ignored.
- An index ≥ C_NUM_REGS is out-of-range.

Write path states: W_IDLE → W_COMMIT → W_RESP → W_IDLE.
- In W_IDLE, AWREADY = 1 until an AW is captured, and WREADY = 1 until a W is captured. AW and W may arrive in either order or in the same cycle.
- When both are held, go to W_COMMIT. AWREADY and WREADY are 0 from then until the return to W_IDLE.
- W_COMMIT (one cycle): for each byte b with WSTRB[b] = 1, reg[idx] byte b ← WDATA byte b. Then set BVALID = 1 and go to W_RESP.
- W_RESP: hold BVALID and BRESP until BREADY. On the BVALID·BREADY edge, clear BVALID and both capture flags, and return to W_IDLE.
- WSTRB = 0: the register is unchanged and BRESP = OKAY.

Read path states: R_IDLE → R_DATA → R_IDLE.
- In R_IDLE, ARREADY = 1.
- On the AR handshake edge: RDATA ← reg[idx], RVALID ← 1, ARREADY ← 0, go to R_DATA.
- R_DATA: hold RDATA, RRESP and RVALID until RREADY. On the RVALID·RREADY edge, clear RVALID and return to R_IDLE.

Read/write independence and collisions:
- The read and write paths are fully independent and may be active concurrently.
- If the W_COMMIT edge coincides with an AR handshake edge to the same index, RDATA returns the pre-write value.

Reset:
- S_AXI_ARESETN = 0 at any edge, including mid-transaction, forces both FSMs to idle, clears capture flags, and zeroes all registers.
- A pending B or R response is dropped.

## Timing
Output values during reset:
- READY/VALID outputs: AWREADY = WREADY = ARREADY = 0; BVALID = RVALID = 0.
- Response and data outputs: BRESP = RRESP = 2'b00; RDATA = 0; reg_q = 0.
- AWREADY, WREADY and ARREADY rise in the first cycle after reset deasserts.

Latencies:
- Write: last of the AW/W handshakes at edge E0; reg_q updated at edge E1; BVALID high from E1. Minimum AW → BVALID is 2 edges.
- Write throughput: back-to-back writes with BREADY tied high take 3 cycles each.
- Read: AR handshake at edge E0; RVALID high from E0. Back-to-back reads with RREADY tied high take 2 cycles each.

Handshake rules:
- All outputs are registered.
- No VALID output depends combinationally on an input READY.
- VALID, once asserted, stays asserted until its handshake completes.

## Configuration
- `AXIL_REGBANK_SLVERR_EN` defined: an out-of-range write returns BRESP = 2'b10 (SLVERR) and an out-of-range read returns RRESP = 2'b10 with RDATA = 0. No register changes.
- Undefined: out-of-range accesses return OKAY. Writes are dropped and reads return 0.
- In-range behaviour and all handshake timing are identical either way.

## Test plan
- Reset, then read all 16 registers → each RDATA = 0x00000000, RRESP = OKAY; ARREADY is 0 during reset.
- Write 0x1..0x4 to byte addresses 0x00, 0x04, 0x08, 0x0C, then read back → 0x1..0x4; reg_q[127:0] = 0x00000004_00000003_00000002_00000001.
- Write 0xAABBCCDD to reg 5, then write 0x11223344 to reg 5 with WSTRB = 4'b0101 → read = 0xAA22CC44.
- Present W three cycles before AW, then AW three cycles before W, and AW and W in the same cycle → each yields exactly one BVALID pulse and correct data; the response is held while BREADY is low for 5 cycles.
- Write 0x12345678 to address 0x40 (index 16, C_NUM_REGS = 16):
  - With the macro: BRESP = 2'b10; a read of 0x40 gives RRESP = 2'b10, RDATA = 0.
  - Without the macro: BRESP = 2'b00, and reg_q is unchanged.
- Collision and mid-transaction reset:
  - With reg 2 = 0x5, align an AR to 0x08 with the W_COMMIT of 0x9 to reg 2 → RDATA = 0x5; a subsequent read returns 0x9.
  - Assert S_AXI_ARESETN = 0 while BVALID = 1 → BVALID is 0 at the next edge and all registers read 0.
